// File: rtl/seq_scan_pkg.sv
// Shared definitions for the serial scan controller and its pattern detector.
//   - Controller state encodings (also driven onto the LED state display).
//   - The two 4-bit window patterns the detector recognises.
package seq_scan_pkg;

    localparam logic [1:0] ST_IDLE  = 2'b00;
    localparam logic [1:0] ST_SHIFT = 2'b01;
    localparam logic [1:0] ST_DONE  = 2'b10;

    // Window patterns, oldest bit in the MSB.
    localparam logic [3:0] PAT_ALL_ONES = 4'b1111;
    localparam logic [3:0] PAT_GAP      = 4'b1101;

endpackage

// File: rtl/seq_window_detect.sv
// Sliding 4-bit window detector for the serial scan stream.
// Ports:
//   clock     in   rising-edge clock
//   resetn    in   synchronous active-low reset
//   clear     in   empty the window and drop match (start of a new scan)
//   shift_en  in   shift bit_in into the window this edge
//   bit_in    in   serial bit presented this cycle
//   match     out  registered detection flag
//   hit       out  detection that will be registered at this edge (lets the
//                  parent count in step with match)
module seq_window_detect
    import seq_scan_pkg::*;
(
    input  logic clock,
    input  logic resetn,
    input  logic clear,
    input  logic shift_en,
    input  logic bit_in,
    output logic match,
    output logic hit
);

    logic [3:0] hist;
    logic [1:0] fill;
    logic [3:0] hist_next;

    assign hist_next = {hist[2:0], bit_in};

    // fill==3 means three bits are already in the window, so after this
    // shift at least four bits of the current scan have been seen.
    assign hit = shift_en && (fill == 2'd3) &&
                 ((hist_next == PAT_ALL_ONES) || (hist_next == PAT_GAP));

    always_ff @(posedge clock) begin
        if (!resetn) begin
            hist  <= '0;
            fill  <= '0;
            match <= 1'b0;
        end else if (clear) begin
            hist  <= '0;
            fill  <= '0;
            match <= 1'b0;
        end else if (shift_en) begin
            hist  <= hist_next;
            if (fill != 2'd3)
                fill <= fill + 1'b1;
            match <= hit;
        end else begin
            // Leaving DONE (or idling) drops the flag.
            match <= 1'b0;
        end
    end

endmodule

// File: rtl/seq_scan_ctrl.sv
// Serial scan controller: latches a word on start, shifts it out MSB first
// for WIDTH cycles, and counts 1111/1101 window detections along the way.
// Ports:
//   clock        in   rising-edge clock
//   resetn       in   synchronous active-low reset
//   start        in   scan request, honoured only in IDLE
//   data_in      in   WIDTH-bit word to scan
//   busy         out  high during SHIFT
//   done         out  one-cycle completion pulse (DONE state)
//   bit_out      out  serial bit this cycle, 0 outside SHIFT
//   match        out  registered detector flag
//   match_count  out  saturating detection count for current/last scan
//   state_out    out  state encoding for the LED display
module seq_scan_ctrl
    import seq_scan_pkg::*;
#(
    parameter int WIDTH = 8,
    parameter int CNT_W = $clog2(WIDTH-2)
) (
    input  logic             clock,
    input  logic             resetn,
    input  logic             start,
    input  logic [WIDTH-1:0] data_in,
    output logic             busy,
    output logic             done,
    output logic             bit_out,
    output logic             match,
    output logic [CNT_W-1:0] match_count,
    output logic [1:0]       state_out
);

    localparam int IDX_W = $clog2(WIDTH);

    logic [1:0]       state;
    logic [1:0]       state_next;
    logic [WIDTH-1:0] sreg;
    logic [IDX_W-1:0] idx;
    logic [CNT_W-1:0] count;
    logic             accept;
    logic             last_bit;
    logic             hit;

    assign accept   = (state == ST_IDLE) && start;
    assign last_bit = (idx == IDX_W'(WIDTH-1));

    // Next-state logic; any unused encoding recovers to IDLE.
    always_comb begin
        state_next = ST_IDLE;
        case (state)
            ST_IDLE:  state_next = start ? ST_SHIFT : ST_IDLE;
            ST_SHIFT: state_next = last_bit ? ST_DONE : ST_SHIFT;
            ST_DONE:  state_next = ST_IDLE;
            default:  state_next = ST_IDLE;
        endcase
    end

    always_ff @(posedge clock) begin
        if (!resetn) begin
            state <= ST_IDLE;
            sreg  <= '0;
            idx   <= '0;
            count <= '0;
        end else begin
            state <= state_next;
            if (accept) begin
                sreg  <= data_in;
                idx   <= '0;
                count <= '0;
            end else if (state == ST_SHIFT) begin
                sreg <= {sreg[WIDTH-2:0], 1'b0};
                idx  <= idx + 1'b1;
                if (hit && (count != '1))
                    count <= count + 1'b1;
            end
        end
    end

    seq_window_detect u_detect (
        .clock    (clock),
        .resetn   (resetn),
        .clear    (accept),
        .shift_en (state == ST_SHIFT),
        .bit_in   (bit_out),
        .match    (match),
        .hit      (hit)
    );

    // Output logic
    always_comb begin
        busy    = (state == ST_SHIFT);
        done    = (state == ST_DONE);
        bit_out = (state == ST_SHIFT) ? sreg[WIDTH-1] : 1'b0;
    end

    assign match_count = count;
    assign state_out   = state;

endmodule

// File: tb/tb_seq_scan_ctrl.sv
module tb_seq_scan_ctrl;

    localparam int W    = 8;
    localparam int CW   = 3;
    localparam int CMAX = (1 << CW) - 1;

    logic          clock = 1'b0;
    logic          resetn;
    logic          start;
    logic [W-1:0]  data_in;
    logic          busy;
    logic          done;
    logic          bit_out;
    logic          match;
    logic [CW-1:0] match_count;
    logic [1:0]    state_out;

    int passed = 0;
    int total  = 0;

    seq_scan_ctrl #(.WIDTH(W), .CNT_W(CW)) dut (
        .clock       (clock),
        .resetn      (resetn),
        .start       (start),
        .data_in     (data_in),
        .busy        (busy),
        .done        (done),
        .bit_out     (bit_out),
        .match       (match),
        .match_count (match_count),
        .state_out   (state_out)
    );

    always #5 clock = ~clock;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        assert (obs === exp) passed++;
        else $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    endtask

    // Reference: bit n (1-based) of a scan is word[W-n]; after n bits a
    // detection exists iff n>=4 and bits n-3..n spell 1111 or 1101.
    function automatic logic ref_hit(input logic [W-1:0] w, input int n);
        logic [3:0] win;
        if (n < 4) return 1'b0;
        win = {w[W-n+3], w[W-n+2], w[W-n+1], w[W-n]};
        return (win == 4'b1111) || (win == 4'b1101);
    endfunction

    function automatic int ref_count(input logic [W-1:0] w);
        int c = 0;
        for (int n = 1; n <= W; n++)
            if (ref_hit(w, n)) c++;
        return (c > CMAX) ? CMAX : c;
    endfunction

    // Full scan; when inject >= 0 a start pulse is raised in the SHIFT
    // cycle whose bit index equals inject, with a different data word.
    task automatic run_scan(input logic [W-1:0] w, input int inject);
        int exp_cnt;
        exp_cnt = ref_count(w);
        data_in = w;
        start   = 1'b1;
        @(negedge clock);
        start   = 1'b0;
        for (int n = 1; n <= W; n++) begin
            check("busy",    32'(busy),      32'd1);
            check("done_lo", 32'(done),      32'd0);
            check("state_s", 32'(state_out), 32'd1);
            check("bit_out", 32'(bit_out),   32'(w[W-n]));
            check("match_s", 32'(match),     32'(ref_hit(w, n-1)));
            if (n - 1 == inject) begin
                start   = 1'b1;
                data_in = ~w;
            end else begin
                start = 1'b0;
            end
            @(negedge clock);
        end
        start = 1'b0;
        check("done_hi", 32'(done),        32'd1);
        check("busy_d",  32'(busy),        32'd0);
        check("state_d", 32'(state_out),   32'd2);
        check("bit_d",   32'(bit_out),     32'd0);
        check("match_d", 32'(match),       32'(ref_hit(w, W)));
        check("count_d", 32'(match_count), 32'(exp_cnt));
        @(negedge clock);
        check("state_i", 32'(state_out),   32'd0);
        check("done_i",  32'(done),        32'd0);
        check("match_i", 32'(match),       32'd0);
        check("count_i", 32'(match_count), 32'(exp_cnt));
    endtask

    initial begin
        logic [W-1:0] w;
        int k;

        // Reset with start held high: start must be ignored.
        resetn  = 1'b0;
        start   = 1'b1;
        data_in = 8'hFF;
        @(negedge clock);
        @(negedge clock);
        check("rst_state", 32'(state_out),   32'd0);
        check("rst_busy",  32'(busy),        32'd0);
        check("rst_done",  32'(done),        32'd0);
        check("rst_bit",   32'(bit_out),     32'd0);
        check("rst_match", 32'(match),       32'd0);
        check("rst_count", 32'(match_count), 32'd0);
        start  = 1'b0;
        resetn = 1'b1;
        @(negedge clock);
        check("post_rst_state", 32'(state_out), 32'd0);

        // Directed words.
        run_scan(8'hFF, -1);
        check("ff_count", 32'(match_count), 32'd5);
        run_scan(8'b1101_0000, -1);
        check("d0_count", 32'(match_count), 32'd1);
        run_scan(8'b1101_1011, -1);
        check("db_count", 32'(match_count), 32'd2);
        run_scan(8'h00, -1);
        check("00_count", 32'(match_count), 32'd0);

        // History must not carry across scans.
        run_scan(8'hFF, -1);
        run_scan(8'b1000_0000, -1);
        check("carry_count", 32'(match_count), 32'd0);

        // IDLE holds results while start is low.
        run_scan(8'b1111_1101, -1);
        for (int i = 0; i < 3; i++) begin
            data_in = W'($urandom);
            @(negedge clock);
            check("hold_state", 32'(state_out),   32'd0);
            check("hold_count", 32'(match_count), 32'(ref_count(8'b1111_1101)));
        end

        // Start during SHIFT is ignored.
        run_scan(8'b1101_1011, 3);

        // Randomized scans.
        for (int r = 0; r < 10; r++) begin
            w = W'($urandom);
            run_scan(w, -1);
        end

        // Reset in the SHIFT cycle with bit index 5, start raised too.
        data_in = 8'hFF;
        start   = 1'b1;
        @(negedge clock);
        start = 1'b0;
        for (int n = 1; n <= 5; n++) @(negedge clock);
        check("pre_rst_busy", 32'(busy), 32'd1);
        resetn = 1'b0;
        start  = 1'b1;
        @(negedge clock);
        check("mid_rst_state", 32'(state_out),   32'd0);
        check("mid_rst_busy",  32'(busy),        32'd0);
        check("mid_rst_count", 32'(match_count), 32'd0);
        check("mid_rst_match", 32'(match),       32'd0);
        resetn = 1'b1;
        start  = 1'b0;
        k = 0;
        for (int i = 0; i < W + 3; i++) begin
            @(negedge clock);
            if (done) k++;
        end
        check("mid_rst_no_done", 32'(k), 32'd0);
        check("mid_rst_idle",    32'(state_out), 32'd0);

        $display("%0d/%0d checks passed", passed, total);
        $finish;
    end

endmodule

// File: doc/seq_scan_ctrl.md
SEQ_SCAN_CTRL -- requirements
Module: seq_scan_ctrl

Interface
REQ-001 Parameter: WIDTH, 8, number of bits in one scan word (WIDTH >= 4).
REQ-002 Parameter: CNT_W, $clog2(WIDTH-2), width of match counter; holds max count WIDTH-3.
REQ-003 Port: clock  input  1  rising-edge system clock.
REQ-004 Port: resetn  input  1  reset; synchronous, active-low.
REQ-005 Port: start  input  1  request to scan data_in; sampled only in IDLE.
REQ-006 Port: data_in  input  WIDTH  word to scan, serialized MSB first.
REQ-007 Port: busy  output  1  high while in SHIFT.
REQ-008 Port: done  output  1  one-cycle pulse, scan complete.
REQ-009 Port: bit_out  output  1  serial bit presented to the detector this cycle.
REQ-010 Port: match  output  1  registered detector output: last 4 scanned bits form a pattern.
REQ-011 Port: match_count  output  CNT_W  number of detections in current/last scan.
REQ-012 Port: state_out  output  2  current controller state encoding, for LED display.

Function
REQ-013 Controller FSM states: IDLE, SHIFT, DONE; any other encoding SHALL go to IDLE next cycle.
REQ-014 IDLE: on start=1, at that edge latch data_in into shift register, clear bit index, detector history, match and match_count, go to SHIFT.
REQ-015 IDLE with start=0: hold state and all result outputs (match_count retains last scan's value).
REQ-016 SHIFT: bit_out = shift register MSB; at each edge shift left one place, increment bit index.
REQ-017 SHIFT lasts exactly WIDTH cycles, then DONE; a start edge at cycle k gives done=1 during cycle k+WIDTH+1.
REQ-018 DONE: done=1 for exactly one cycle, busy=0, then IDLE unconditionally.
REQ-019 start asserted in SHIFT or DONE SHALL be ignored (not queued).
REQ-020 Detector: 4-bit history, oldest to newest; at each SHIFT edge history shifts in bit_out.
REQ-021 Detector match SHALL be set at an edge iff updated history equals 1111 or 1101 and at least 4 bits of the current scan have been shifted; otherwise cleared.
REQ-022 Overlapping detections count; match_count increments at each edge where match is set, saturating at 2^CNT_W-1.
REQ-023 bit_out SHALL be 0 outside SHIFT.
REQ-024 match SHALL clear at the edge leaving DONE; match_count persists until next accepted start.
REQ-025 state_out encodings: IDLE=2'b00, SHIFT=2'b01, DONE=2'b10.

Reset
REQ-026 resetn=0 at a rising edge SHALL force IDLE regardless of state, including mid-SHIFT.
REQ-027 Reset values: busy=0, done=0, bit_out=0, match=0, match_count=0, state_out=2'b00, shift register, index and history all 0.
REQ-028 start sampled in the same cycle as resetn=0 SHALL be ignored.

Structure
REQ-029 Shared package seq_scan_pkg SHALL hold the state encodings and the two pattern constants (4'b1111, 4'b1101).
REQ-030 Detector history and match logic SHALL be a sub-module seq_window_detect (inputs clock, resetn, clear, shift_en, bit_in; output match).
REQ-031 Controller FSM, shift register, bit index and counter stay in seq_scan_ctrl; next-state logic separate from output logic.

Verification
REQ-032 data_in=8'hFF, start one cycle -> busy 8 cycles, match high on last 5 SHIFT edges, done at cycle 9, match_count=5.
REQ-033 data_in=8'b11010000 -> one detection after 4th bit, match_count=1.
REQ-034 data_in=8'b11011011 -> detections after bits 4 and 7, match_count=2; data_in=8'h00 -> match_count=0.
REQ-035 Scan 8'hFF then 8'b10000000 -> second scan match_count=0 (history cleared; no carry-over).
REQ-036 start pulsed during SHIFT at index 3 -> ignored, done still at original cycle, results match first word.
REQ-037 resetn=0 at SHIFT index 5 -> next cycle state_out=2'b00, busy=0, match_count=0, no done pulse.
